// File: rtl/pc_seq_pkg.sv
// Shared branch-type encoding for the PC sequencer and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_seq_pkg;

    localparam int BR_TYPE_W = 3;

    typedef enum logic [BR_TYPE_W-1:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_CBZ  = 3'd2,
        BR_CBNZ = 3'd3,
        BR_BL   = 3'd4,
        BR_BR   = 3'd5,
        BR_RET  = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle: branch request in, fetch address out.
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold mechanism; there is no ready/valid.
// Ports: master drives stall/br_type/z_flag/br_offset/reg_target and observes
//        pc/pc_next/taken/link_addr/ras_empty/ras_overflow; slave is the reverse.
interface pc_sequencer_if #(
    parameter int ADDR_W = 64
);
    import pc_seq_pkg::*;

    logic                 stall;
    logic [BR_TYPE_W-1:0] br_type;
    logic                 z_flag;
    logic [ADDR_W-1:0]    br_offset;
    logic [ADDR_W-1:0]    reg_target;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_next;
    logic                 taken;
    logic [ADDR_W-1:0]    link_addr;
    logic                 ras_empty;
    logic                 ras_overflow;

    modport master (
        output stall, br_type, z_flag, br_offset, reg_target,
        input  pc, pc_next, taken, link_addr, ras_empty, ras_overflow
    );

    modport slave (
        input  stall, br_type, z_flag, br_offset, reg_target,
        output pc, pc_next, taken, link_addr, ras_empty, ras_overflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Latency: push/pop commit at the rising edge; top/empty reflect registered state.
// Backpressure: none; overflow is a sticky flag, pops on empty are ignored.
// Ports: clk, rst (async high), push/pop strobes, push_data in, top/empty/overflow out.
module return_addr_stack #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;       // index of the current top entry
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [CNT_W-1:0]  cnt;
    logic              full;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign ptr_inc = ptr + PTR_W'(1);
    assign ptr_dec = ptr - PTR_W'(1);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign top     = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            ptr <= ptr_inc;
            // Full push lands on the oldest slot; occupancy stays saturated.
            if (full) begin
                overflow <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr <= ptr_dec;
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Data contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_inc] <= push_data;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch decode, PC register and return-address stack.
// Latency: pc_next/taken/link_addr combinational; pc updates at the next edge.
// Backpressure: stall holds pc and the RAS; decode outputs still track inputs.
// Ports: clk, rst (async high), bus (pc_sequencer_if.slave) carrying branch
//        request inputs and pc/pc_next/taken/link_addr/ras_empty/ras_overflow.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int unsigned       PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);
    br_type_e          bt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_overflow;
    logic              ras_push;
    logic              ras_pop;
    logic              taken;
    logic [ADDR_W-1:0] pc_next;

    assign bt  = br_type_e'(bus.br_type);
    assign seq = pc_q + ADDR_W'(PC_STEP);
    assign rel = pc_q + bus.br_offset;

    always_comb begin
        taken   = 1'b0;
        pc_next = seq;
        case (bt)
            BR_B, BR_BL: begin
                taken   = 1'b1;
                pc_next = rel;
            end
            BR_CBZ: begin
                taken   = bus.z_flag;
                pc_next = bus.z_flag ? rel : seq;
            end
            BR_CBNZ: begin
                taken   = !bus.z_flag;
                pc_next = bus.z_flag ? seq : rel;
            end
            BR_BR: begin
                taken   = 1'b1;
                pc_next = bus.reg_target;
            end
            BR_RET: begin
                // An empty stack falls back to the register target silently.
                taken   = 1'b1;
                pc_next = ras_empty ? bus.reg_target : ras_top;
            end
            default: begin
                taken   = 1'b0;
                pc_next = seq;
            end
        endcase
    end

    assign ras_push = !bus.stall && (bt == BR_BL);
    assign ras_pop  = !bus.stall && (bt == BR_RET) && !ras_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (!bus.stall) begin
            pc_q <= pc_next;
        end
    end

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );

    assign bus.pc           = pc_q;
    assign bus.pc_next      = pc_next;
    assign bus.taken        = taken;
    assign bus.link_addr    = seq;
    assign bus.ras_empty    = ras_empty;
    assign bus.ras_overflow = ras_overflow;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected pc values are queued as
// stimulus is applied and compared against pc sampled after each edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(64)) bus ();

    pc_sequencer #(
        .ADDR_W    (64),
        .PC_STEP   (1),
        .RESET_PC  (64'h100),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_in(input logic [2:0] bt, input logic z, input logic [63:0] off,
                          input logic [63:0] tgt, input logic st);
        @(negedge clk);
        bus.br_type    = bt;
        bus.z_flag     = z;
        bus.br_offset  = off;
        bus.reg_target = tgt;
        bus.stall      = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obs_q.push_back(bus.pc);
    endtask

    task automatic expect_pc(input logic [63:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic goto_pc(input logic [63:0] a);
        set_in(BR_BR, 1'b0, 64'h0, a, 1'b0);
        expect_pc(a, "goto");
        tick();
    endtask

    task automatic drain_pc();
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            logic [63:0] o;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++;
                $display("FAIL %s: no pc sample, expected %h", t, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    err_cnt++;
                    $display("FAIL %s: pc got %h expected %h", t, o, e);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.br_type    = BR_NONE;
        bus.z_flag     = 1'b0;
        bus.br_offset  = '0;
        bus.reg_target = '0;
        #2;
        chk_cnt++; if (bus.pc !== 64'h100) begin err_cnt++; $display("FAIL rst_pc: got %h expected 100", bus.pc); end
        chk_cnt++; if (bus.pc_next !== 64'h101) begin err_cnt++; $display("FAIL rst_pc_next: got %h expected 101", bus.pc_next); end
        chk_cnt++; if (bus.taken !== 1'b0) begin err_cnt++; $display("FAIL rst_taken: got %b expected 0", bus.taken); end
        chk_cnt++; if (bus.ras_empty !== 1'b1 || bus.ras_overflow !== 1'b0) begin
            err_cnt++; $display("FAIL rst_ras: empty %b ovf %b expected 1 0", bus.ras_empty, bus.ras_overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            expect_pc(64'h100 + 64'(i), "seq_after_reset");
            tick();
        end
        drain_pc();
    endtask

    task automatic test_cond_branch();
        goto_pc(64'h10);
        set_in(BR_CBNZ, 1'b0, -64'sd4, 64'h0, 1'b0);
        chk_cnt++; if (bus.taken !== 1'b1) begin err_cnt++; $display("FAIL cbnz_taken: got %b expected 1", bus.taken); end
        expect_pc(64'h0C, "cbnz_taken_pc");
        tick();
        goto_pc(64'h10);
        set_in(BR_CBNZ, 1'b1, -64'sd4, 64'h0, 1'b0);
        chk_cnt++; if (bus.taken !== 1'b0) begin err_cnt++; $display("FAIL cbnz_not_taken: got %b expected 0", bus.taken); end
        expect_pc(64'h11, "cbnz_fall_pc");
        tick();
        goto_pc(64'h10);
        set_in(BR_CBZ, 1'b1, 64'h8, 64'h0, 1'b0);
        chk_cnt++; if (bus.taken !== 1'b1) begin err_cnt++; $display("FAIL cbz_taken: got %b expected 1", bus.taken); end
        expect_pc(64'h18, "cbz_taken_pc");
        tick();
        set_in(BR_RSVD, 1'b1, 64'h8, 64'h77, 1'b0);
        chk_cnt++; if (bus.taken !== 1'b0) begin err_cnt++; $display("FAIL rsvd_taken: got %b expected 0", bus.taken); end
        expect_pc(64'h19, "rsvd_pc");
        tick();
        drain_pc();
    endtask

    task automatic test_bl_ret();
        goto_pc(64'h20);
        set_in(BR_BL, 1'b0, 64'h40, 64'h0, 1'b0);
        chk_cnt++; if (bus.link_addr !== 64'h21) begin err_cnt++; $display("FAIL bl_link: got %h expected 21", bus.link_addr); end
        expect_pc(64'h60, "bl_pc");
        tick();
        chk_cnt++; if (bus.ras_empty !== 1'b0) begin err_cnt++; $display("FAIL bl_ras_empty: got %b expected 0", bus.ras_empty); end
        set_in(BR_RET, 1'b0, 64'h0, 64'hDEAD, 1'b0);
        expect_pc(64'h21, "ret_pc");
        tick();
        chk_cnt++; if (bus.ras_empty !== 1'b1) begin err_cnt++; $display("FAIL ret_ras_empty: got %b expected 1", bus.ras_empty); end
        drain_pc();
    endtask

    task automatic test_ras_overflow();
        logic [63:0] call_pc [5];
        logic [63:0] ret_pc [4];
        call_pc = '{64'h1, 64'h11, 64'h21, 64'h31, 64'h41};
        ret_pc  = '{64'h42, 64'h32, 64'h22, 64'h12};
        for (int i = 0; i < 5; i++) begin
            goto_pc(call_pc[i]);
            set_in(BR_BL, 1'b0, 64'h100, 64'h0, 1'b0);
            expect_pc(call_pc[i] + 64'h100, "nested_bl_pc");
            tick();
            if (i == 3) begin
                chk_cnt++; if (bus.ras_overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_early: got %b expected 0", bus.ras_overflow); end
            end
        end
        chk_cnt++; if (bus.ras_overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got %b expected 1", bus.ras_overflow); end
        for (int i = 0; i < 4; i++) begin
            set_in(BR_RET, 1'b0, 64'h0, 64'h999, 1'b0);
            expect_pc(ret_pc[i], "nested_ret_pc");
            tick();
        end
        chk_cnt++; if (bus.ras_empty !== 1'b1) begin err_cnt++; $display("FAIL ras_drained: got %b expected 1", bus.ras_empty); end
        set_in(BR_RET, 1'b0, 64'h0, 64'h999, 1'b0);
        expect_pc(64'h999, "ret_empty_pc");
        tick();
        drain_pc();
    endtask

    task automatic test_stall();
        goto_pc(64'h50);
        set_in(BR_B, 1'b0, 64'h30, 64'h0, 1'b1);
        chk_cnt++; if (bus.taken !== 1'b1 || bus.pc_next !== 64'h80) begin
            err_cnt++; $display("FAIL stall_decode: taken %b pc_next %h expected 1 80", bus.taken, bus.pc_next);
        end
        expect_pc(64'h50, "stall_hold1");
        tick();
        expect_pc(64'h50, "stall_hold2");
        tick();
        set_in(BR_BL, 1'b0, 64'h30, 64'h0, 1'b1);
        expect_pc(64'h50, "stall_bl_hold");
        tick();
        chk_cnt++; if (bus.ras_empty !== 1'b1) begin err_cnt++; $display("FAIL stall_no_push: empty %b expected 1", bus.ras_empty); end
        set_in(BR_B, 1'b0, 64'h30, 64'h0, 1'b0);
        expect_pc(64'h80, "stall_release");
        tick();
        drain_pc();
    endtask

    task automatic test_wrap();
        goto_pc(64'hFFFF_FFFF_FFFF_FFFF);
        set_in(BR_NONE, 1'b0, 64'h0, 64'h0, 1'b0);
        chk_cnt++; if (bus.pc_next !== 64'h0) begin err_cnt++; $display("FAIL wrap_next: got %h expected 0", bus.pc_next); end
        expect_pc(64'h0, "wrap_pc");
        tick();
        drain_pc();
    endtask

    task automatic test_async_reset();
        goto_pc(64'h200);
        set_in(BR_BL, 1'b0, 64'h10, 64'h0, 1'b0);
        expect_pc(64'h210, "pre_rst_bl1");
        tick();
        expect_pc(64'h220, "pre_rst_bl2");
        tick();
        drain_pc();
        chk_cnt++; if (bus.ras_empty !== 1'b0) begin err_cnt++; $display("FAIL pre_rst_ras: empty %b expected 0", bus.ras_empty); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (bus.pc !== 64'h100) begin err_cnt++; $display("FAIL async_rst_pc: got %h expected 100", bus.pc); end
        chk_cnt++; if (bus.ras_empty !== 1'b1 || bus.ras_overflow !== 1'b0) begin
            err_cnt++; $display("FAIL async_rst_ras: empty %b ovf %b expected 1 0", bus.ras_empty, bus.ras_overflow);
        end
        bus.br_type = BR_NONE;
        @(negedge clk);
        rst = 1'b0;
        expect_pc(64'h101, "post_rst_seq");
        tick();
        drain_pc();
    endtask

    initial begin
        test_reset();
        test_cond_branch();
        test_bl_ret();
        test_ras_overflow();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", err_cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle ARM datapath. It generalises the PC with:
- configurable address width, step and reset vector;
- a full branch-type decode (B, CBZ, CBNZ, BL, BR, RET);
- a pipeline stall input;
- a circular return-address stack (RAS) for BL/RET.

It sits between the control unit and instruction memory and supplies the fetch address every cycle.

## Interface
- `ADDR_W`, 64, width of PC and all address ports
- `PC_STEP`, 1, sequential increment (word-addressed instruction memory)
- `RESET_PC`, 0, PC value on reset
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2)
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: asynchronous, active-high reset
- `stall` input 1: hold PC and RAS this cycle
- `br_type` input 3: 0 NONE, 1 B, 2 CBZ, 3 CBNZ, 4 BL, 5 BR, 6 RET, 7 reserved (treated as NONE)
- `z_flag` input 1: ALU zero flag for CBZ/CBNZ
- `br_offset` input ADDR_W: signed PC-relative offset, already sign-extended
- `reg_target` input ADDR_W: register-sourced target for BR and RET fallback
- `pc` output ADDR_W: current fetch address (registered)
- `pc_next` output ADDR_W: address loaded at next edge when not stalled (combinational)
- `taken` output 1: branch redirect selected this cycle (combinational)
- `link_addr` output ADDR_W: `pc + PC_STEP`, written to X30 by BL
- `ras_empty` output 1: RAS holds no entries (registered)
- `ras_overflow` output 1: sticky; set when BL pushes onto a full RAS, cleared only by reset

## Operation
- Sequential address: `seq = pc + PC_STEP`.
- Relative target: `rel = pc + br_offset`.
- All sums are modulo 2^ADDR_W; wrap-around is silent.
- `taken` and `pc_next` by `br_type`:
  - NONE / reserved: `taken=0`, `pc_next=seq`.
  - B: `taken=1`, `pc_next=rel`.
  - CBZ: `taken=z_flag`.
  - CBNZ: `taken=~z_flag`.
  - CBZ / CBNZ target: `pc_next = taken ? rel : seq`.
  - BL: `taken=1`, `pc_next=rel`; pushes `seq` onto the RAS.
  - BR: `taken=1`, `pc_next=reg_target`.
  - RET when RAS is non-empty: `taken=1`, `pc_next` = top of stack; pops the entry.
  - RET when RAS is empty: `taken=1`, `pc_next=reg_target`; no pop, no error.
- RAS structure:
  - Circular buffer with a top pointer and an occupancy count (0..RAS_DEPTH).
  - A push when full overwrites the oldest entry, keeps count at RAS_DEPTH and sets `ras_overflow`.
- `stall=1`:
  - `pc` holds; no push or pop.
  - `taken` and `pc_next` still reflect the inputs.
- Reset (asynchronous, any time, including mid-branch):
  - `pc=RESET_PC`, RAS count=0, pointer=0, `ras_empty=1`, `ras_overflow=0`.
  - RAS data contents are don't-care.
- Reset values of combinational outputs follow from the registered state. For NONE with `pc=RESET_PC`: `pc_next=RESET_PC+PC_STEP`, `taken=0`.

## Timing
- Zero-latency decode: `pc_next`, `taken` and `link_addr` are valid in the same cycle as their inputs.
- `pc` takes `pc_next` at the rising edge when `stall=0`.
- A push or pop commits at the same edge. A RET immediately after a BL returns that BL's `seq`.
- No back-to-back hazards: one `br_type` per cycle, so push and pop never coincide.
- `rst` deassertion is synchronised externally. The block only requires `rst` to be asynchronous-assert.

## Structure
- Shared package `pc_seq_pkg`:
  - `br_type` enum/localparams (`BR_NONE`…`BR_RET`);
  - the `BR_TYPE_W=3` constant.
- Sub-module `return_addr_stack`:
  - parameters `ADDR_W`, `DEPTH`;
  - ports: `clk`, `rst`, `push`, `pop`, `push_data`, `top`, `empty`, `overflow`;
  - circular overwrite on full.
- Top level holds only the decode, adders, PC register and stall gating.

## Test plan
- Reset with `RESET_PC=0x100`, `PC_STEP=1`, NONE for 3 cycles → `pc` = 0x100, 0x101, 0x102, 0x103.
- At `pc=0x10`:
  - CBNZ, `z_flag=0`, `br_offset=-4` → `taken=1`, next `pc=0x0C`.
  - CBNZ, `z_flag=1` → `pc=0x11`.
  - CBZ, `z_flag=1`, `br_offset=8` → `pc=0x18`.
- At `pc=0x20`: BL, offset 0x40 → `pc=0x60`, `link_addr` was 0x21. RET next cycle → `pc=0x21`, `ras_empty=1`.
- With `RAS_DEPTH=4`:
  - 5 nested BLs from pc 0x1, 0x11, 0x21, 0x31, 0x41 → `ras_overflow=1`.
  - 4 RETs → 0x42, 0x32, 0x22, 0x12.
  - 5th RET with `reg_target=0x999` → `pc=0x999`.
- `stall=1` for 2 cycles during B → `pc` unchanged, RAS count unchanged. Release → branch taken.
- `pc=2^64-1`, NONE → `pc=0`.
- Assert `rst` mid-cycle after 2 BLs → `pc=RESET_PC` immediately, `ras_empty=1`, `ras_overflow=0`.
